// File: rtl/pyc_credit_tx.sv
// pyc_credit_tx: credit-gated ready/valid to tx-pulse bridge for a remote fifo with no backpressure.
// Define PYC_CREDIT_TX_ERR_EN to get a sticky credit-overflow flag on err.
module pyc_credit_tx #(
    parameter int WIDTH = 1,
    parameter int CREDITS = 2,
    localparam int CNT_W = ($clog2(CREDITS + 1) < 1) ? 1 : $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             credit_return,
    output logic [CNT_W-1:0] credit_count,
    output logic             idle,
    output logic             err
);
    localparam logic [CNT_W:0] FULL = (CNT_W + 1)'(CREDITS);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_valid_q;
    logic [WIDTH-1:0] tx_data_q;
    logic             accept, overflow;
    logic [CNT_W:0]   sum;
    assign in_ready = cnt_q != '0;
    assign accept   = in_valid && in_ready;
    // one extra bit so a return at a full counter is visible as sum > FULL
    assign sum      = {1'b0, cnt_q} - (CNT_W + 1)'(accept) + (CNT_W + 1)'(credit_return);
    assign overflow = sum > FULL;
    assign cnt_d    = overflow ? FULL[CNT_W-1:0] : sum[CNT_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= FULL[CNT_W-1:0];
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            tx_valid_q <= accept;
            if (accept) tx_data_q <= in_data;
        end
    end
    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign credit_count = cnt_q;
    assign idle         = (cnt_q == FULL[CNT_W-1:0]) && !tx_valid_q;
`ifdef PYC_CREDIT_TX_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (overflow) err_q <= 1'b1;
    end
    assign err = err_q;
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && overflow) $display("pyc_credit_tx: credit overflow, credit dropped at %0t", $time);
    end
`endif
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_pyc_credit_tx.sv
// tb_pyc_credit_tx: directed scenarios with a tx-data scoreboard, CREDITS=2, WIDTH=8.
module tb_pyc_credit_tx;
    localparam int WIDTH = 8;
    localparam int CREDITS = 2;
    localparam int CNT_W = 2;
`ifdef PYC_CREDIT_TX_ERR_EN
    localparam logic ERR_ON_OVF = 1'b1;
`else
    localparam logic ERR_ON_OVF = 1'b0;
`endif
    logic clk = 0, rst = 1, in_valid = 0, credit_return = 0;
    logic [WIDTH-1:0] in_data = '0;
    logic in_ready, tx_valid, idle, err;
    logic [WIDTH-1:0] tx_data;
    logic [CNT_W-1:0] credit_count;
    int n_chk = 0, n_fail = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_d;

    pyc_credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .credit_return(credit_return),
        .credit_count(credit_count), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    // scoreboard consumer: every tx pulse must match the oldest beat the bench expects accepted
    always @(posedge clk) begin
        if (rst) sb.delete();
        else begin
            #1;
            if (tx_valid) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_tx: got tx_data=%h, expected no pulse", tx_data);
                end else begin
                    exp_d = sb.pop_front();
                    if (tx_data !== exp_d) begin
                        n_fail++;
                        $display("FAIL sb_tx_data: got %h, expected %h", tx_data, exp_d);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        n_chk += 5;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
        if (credit_count !== 2'd2) begin n_fail++; $display("FAIL reset_count: got %0d, expected 2", credit_count); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b, expected 1", idle); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
    endtask

    task automatic test_exhaust();
        logic [WIDTH-1:0] d[3] = '{8'h11, 8'h22, 8'h33};
        logic [CNT_W-1:0] c[2] = '{2'd1, 2'd0};
        in_valid = 1;
        for (int i = 0; i < 2; i++) begin
            in_data = d[i];
            sb.push_back(d[i]);
            tick();
            n_chk += 2;
            if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL exhaust_tx_valid%0d: got %b, expected 1", i, tx_valid); end
            if (credit_count !== c[i]) begin n_fail++; $display("FAIL exhaust_count%0d: got %0d, expected %0d", i, credit_count, c[i]); end
        end
        in_data = d[2];
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_in_ready: got %b, expected 0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk += 4;
            if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL holdoff_tx_valid%0d: got %b, expected 0", i, tx_valid); end
            if (tx_data !== 8'h22) begin n_fail++; $display("FAIL holdoff_tx_data%0d: got %h, expected 22", i, tx_data); end
            if (credit_count !== 2'd0) begin n_fail++; $display("FAIL holdoff_count%0d: got %0d, expected 0", i, credit_count); end
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL holdoff_in_ready%0d: got %b, expected 0", i, in_ready); end
        end
    endtask

    task automatic test_credit_at_zero();
        credit_return = 1;
        tick();
        credit_return = 0;
        n_chk += 3;
        if (credit_count !== 2'd1) begin n_fail++; $display("FAIL zero_ret_count: got %0d, expected 1", credit_count); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ret_in_ready: got %b, expected 1", in_ready); end
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL zero_ret_tx_valid: got %b, expected 0", tx_valid); end
        sb.push_back(8'h33);
        tick();
        in_valid = 0;
        n_chk += 2;
        if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL zero_acc_tx_valid: got %b, expected 1", tx_valid); end
        if (credit_count !== 2'd0) begin n_fail++; $display("FAIL zero_acc_count: got %0d, expected 0", credit_count); end
        tick();
        n_chk++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL zero_after_tx_valid: got %b, expected 0", tx_valid); end
    endtask

    task automatic test_simultaneous();
        credit_return = 1;
        tick();
        n_chk++;
        if (credit_count !== 2'd1) begin n_fail++; $display("FAIL simul_setup_count: got %0d, expected 1", credit_count); end
        in_valid = 1;
        in_data = 8'h44;
        sb.push_back(8'h44);
        tick();
        in_valid = 0;
        credit_return = 0;
        n_chk += 2;
        if (credit_count !== 2'd1) begin n_fail++; $display("FAIL simul_count: got %0d, expected 1", credit_count); end
        if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL simul_tx_valid: got %b, expected 1", tx_valid); end
        tick();
        n_chk += 2;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL simul_single_pulse: got %b, expected 0", tx_valid); end
        if (credit_count !== 2'd1) begin n_fail++; $display("FAIL simul_count_after: got %0d, expected 1", credit_count); end
    endtask

    task automatic test_overflow();
        credit_return = 1;
        tick();
        n_chk += 2;
        if (credit_count !== 2'd2) begin n_fail++; $display("FAIL ovf_fill_count: got %0d, expected 2", credit_count); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_fill_err: got %b, expected 0", err); end
        tick();
        credit_return = 0;
        for (int i = 0; i < 3; i++) begin
            n_chk += 3;
            if (credit_count !== 2'd2) begin n_fail++; $display("FAIL ovf_count%0d: got %0d, expected 2", i, credit_count); end
            if (err !== ERR_ON_OVF) begin n_fail++; $display("FAIL ovf_err%0d: got %b, expected %b", i, err, ERR_ON_OVF); end
            if (idle !== 1'b1) begin n_fail++; $display("FAIL ovf_idle%0d: got %b, expected 1", i, idle); end
            tick();
        end
    endtask

    task automatic test_reset_mid_burst();
        in_valid = 1;
        in_data = 8'h55;
        sb.push_back(8'h55);
        tick();
        in_data = 8'h66;
        sb.push_back(8'h66);
        tick();
        n_chk += 3;
        if (credit_count !== 2'd0) begin n_fail++; $display("FAIL mid_pre_count: got %0d, expected 0", credit_count); end
        if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tx_valid: got %b, expected 1", tx_valid); end
        if (idle !== 1'b0) begin n_fail++; $display("FAIL mid_pre_idle: got %b, expected 0", idle); end
        rst = 1;
        in_valid = 0;
        credit_return = 1;
        tick();
        rst = 0;
        credit_return = 0;
        n_chk += 5;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tx_valid: got %b, expected 0", tx_valid); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx_data: got %h, expected 00", tx_data); end
        if (credit_count !== 2'd2) begin n_fail++; $display("FAIL mid_rst_count: got %0d, expected 2", credit_count); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_err: got %b, expected 0", err); end
        if (idle !== 1'b1) begin n_fail++; $display("FAIL mid_rst_idle: got %b, expected 1", idle); end
        tick();
        n_chk += 2;
        if (credit_count !== 2'd2) begin n_fail++; $display("FAIL mid_post_count: got %0d, expected 2", credit_count); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL mid_post_err: got %b, expected 0", err); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'hA0 + i);
            if (i < CREDITS) sb.push_back(in_data);
            tick();
            n_chk++;
            if (tx_valid !== (i < CREDITS)) begin n_fail++; $display("FAIL b2b_tx_valid%0d: got %b, expected %b", i, tx_valid, i < CREDITS); end
        end
        in_valid = 0;
        credit_return = 1;
        tick();
        tick();
        credit_return = 0;
        tick();
        n_chk += 2;
        if (credit_count !== 2'd2) begin n_fail++; $display("FAIL b2b_return_count: got %0d, expected 2", credit_count); end
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_exhaust();
        test_credit_at_zero();
        test_simultaneous();
        test_overflow();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pyc_credit_tx.md
Name: pyc_credit_tx

Overview:
- Producer-side endpoint for a remote `pyc_fifo`-style buffer reached over a fixed-latency link that carries no ready signal.
- Accepts a local ready/valid stream and forwards beats as one-cycle tx pulses.
- Sends only while it holds credits; the remote FIFO returns one credit per pop.
- Its job is to guarantee the remote buffer is never overrun, without any backpressure wire.

Parameters:
- WIDTH, 1, data width in bits.
- CREDITS, 2, initial credit count; must equal the remote buffer DEPTH, and must be >= 1.
- CNT_W, clog2(CREDITS+1) (localparam, min 1), credit counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  producer beat payload.
- tx_valid  output  1  one-cycle pulse per beat sent to the remote buffer.
- tx_data  output  WIDTH  payload; meaningful only when tx_valid=1.
- credit_return  input  1  pulse; one credit returned per cycle it is high.
- credit_count  output  CNT_W  current credit counter value.
- idle  output  1  all credits home and no beat in flight on tx.
- err  output  1  sticky credit-overflow flag (see Optional Feature).

Behaviour:
- Reset: clk, rst are synchronous, active-high.
  - cnt <= CREDITS, tx_valid <= 0, tx_data <= 0, err <= 0.
  - in_ready therefore reads 1 in the first cycle after reset.
- in_ready = (cnt != 0). It is combinational from cnt only and never depends on in_valid or credit_return.
- accept = in_valid && in_ready.
- Latency 1: on accept, at the next edge tx_valid <= 1 and tx_data <= in_data.
  - Otherwise tx_valid <= 0 and tx_data holds its value (no toggle when idle).
- tx has no backpressure. Every tx_valid pulse is exactly one beat the remote must absorb.
- Counter update, cnt_next = cnt - accept + credit_return, evaluated in CNT_W+1 bits:
  - accept only: cnt - 1.
  - credit_return only: cnt + 1.
  - both in the same cycle: cnt is unchanged, and the accept is legal because cnt != 0 was already required.
  - cnt==0 with credit_return: cnt becomes 1, and in_ready rises the next cycle (no same-cycle bypass).
- Overflow: credit_return while cnt==CREDITS with no accept is illegal.
  - cnt saturates at CREDITS, i.e. the credit is dropped.
  - err behaviour is described under Optional Feature.
- Underflow is impossible by construction, since accept requires cnt != 0.
- Back-to-back: a beat can be accepted every cycle while cnt != 0.
  - With CREDITS=N and no returns, exactly N beats are accepted and then in_ready=0.
- idle = (cnt == CREDITS) && !tx_valid.
- credit_count = cnt, registered.
- Reset mid-operation: all state returns to reset values in the next cycle and any in-flight beat is lost.
  - The remote buffer must be reset in the same cycle.
  - A credit_return arriving during the reset cycle is ignored.
- Input stability: when in_ready=0, the block ignores in_valid/in_data. The producer must hold in_valid and in_data stable until accept.

Optional Feature:
- Macro: PYC_CREDIT_TX_ERR_EN.
- Defined:
  - err is set on the first overflow event and stays 1 until rst.
  - Under `ifndef SYNTHESIS`, a simulation $display error is also printed on the overflow cycle.
- Undefined:
  - err is tied to constant 0 and no overflow-detect logic is instantiated.
  - Saturation of cnt is retained.

Test Plan:
- Reset check, CREDITS=2, WIDTH=8: assert rst for 2 cycles -> tx_valid=0, credit_count=2, in_ready=1, idle=1, err=0.
- Credit exhaustion, CREDITS=2, in_valid held high with data 0x11, 0x22, 0x33 -> tx pulses carry 0x11 then 0x22 on consecutive cycles; credit_count goes 1 then 0; in_ready=0; 0x33 is held off.
- Credit return at cnt=0: pulse credit_return once -> credit_count=1 next cycle, in_ready=1 the same cycle, 0x33 accepted, and tx_valid carries 0x33 one cycle after acceptance.
- Simultaneous events at cnt=1: accept + credit_return in the same cycle -> credit_count stays 1 and exactly one tx pulse follows.
- Overflow with macro defined, cnt=2: pulse credit_return -> credit_count stays 2 and err=1 persists until rst. With macro undefined, err=0 and cnt stays 2.
- Reset mid-burst, cnt=0, tx_valid=1: assert rst for 1 cycle -> next cycle tx_valid=0, credit_count=2; a credit_return asserted during rst is ignored.
